// File: rtl/packet_forwarder.sv
// Single-register AXI-stream forwarder that stamps each packet with a rotating reorder tag.
// Optional oversize truncation with drain is enabled by defining FWD_OVERSIZE_TRUNC_EN.
module packet_forwarder #(
   parameter int unsigned TAG_WIDTH            = 6,
   parameter int unsigned CIRCULAR_BUFFER_SIZE = 50,
   parameter int unsigned DATA_WIDTH           = 64,
   parameter int unsigned MAX_TDATA_PER_PACKET = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_axis_TDATA,
   input  logic                  s_axis_TVALID,
   input  logic                  s_axis_TLAST,
   output logic                  s_axis_TREADY,
   input  logic                  fwd_rdy,
   output logic [DATA_WIDTH-1:0] buffer_TDATA,
   output logic [TAG_WIDTH-1:0]  reorder_tag,
   output logic                  buffer_TLAST,
   output logic                  buffer_TVALID,
   output logic                  tag_alloc_valid,
   output logic [TAG_WIDTH-1:0]  tag_alloc,
   output logic [15:0]           pkt_count
);

`ifdef FWD_OVERSIZE_TRUNC_EN
   typedef enum logic [1:0] {IDLE, PASS, DRAIN} state_e;
`else
   typedef enum logic {IDLE, PASS} state_e;
`endif

   state_e                state_q, state_d;
   logic                  ready_en_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  last_q, vld_q, alloc_q;
   logic [TAG_WIDTH-1:0]  otag_q, alloc_tag_q, tag_q, tag_d;
   logic [8:0]            cnt_q;
   logic [15:0]           pkt_q;
   logic                  accept, fwd_accept, xfer, eff_last, trunc, in_drain;

   always_comb begin
      xfer   = vld_q && fwd_rdy;
      accept = s_axis_TVALID && s_axis_TREADY;
`ifdef FWD_OVERSIZE_TRUNC_EN
      in_drain = (state_q == DRAIN);
      trunc    = accept && !in_drain && !s_axis_TLAST
                 && (cnt_q == 9'(MAX_TDATA_PER_PACKET - 1));
`else
      in_drain = 1'b0;
      trunc    = 1'b0;
`endif
      fwd_accept = accept && !in_drain;
      eff_last   = s_axis_TLAST || trunc;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, PASS: begin
            if (fwd_accept) state_d = eff_last ? IDLE : PASS;
`ifdef FWD_OVERSIZE_TRUNC_EN
            if (trunc) state_d = DRAIN;
         end
         DRAIN: begin
            if (accept && s_axis_TLAST) state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // ready_en_q holds TREADY low until the first edge after reset release
   always_comb begin
      s_axis_TREADY = ready_en_q && (in_drain || !vld_q || fwd_rdy);
   end

   always_comb begin
      tag_d = tag_q;
      if (fwd_accept && eff_last)
         tag_d = (tag_q == TAG_WIDTH'(CIRCULAR_BUFFER_SIZE - 1)) ? '0 : tag_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ready_en_q  <= 1'b0;
         data_q      <= '0;
         last_q      <= 1'b0;
         vld_q       <= 1'b0;
         otag_q      <= '0;
         alloc_q     <= 1'b0;
         alloc_tag_q <= '0;
         tag_q       <= '0;
         cnt_q       <= '0;
         pkt_q       <= '0;
      end else begin
         ready_en_q <= 1'b1;
         tag_q      <= tag_d;
         alloc_q    <= fwd_accept && (state_q == IDLE);
         if (fwd_accept && (state_q == IDLE)) alloc_tag_q <= tag_q;
         if (fwd_accept) begin
            data_q <= s_axis_TDATA;
            last_q <= eff_last;
            otag_q <= tag_q;
            vld_q  <= 1'b1;
         end else if (xfer) begin
            vld_q  <= 1'b0;
         end
         if (accept) begin
            if (eff_last)       cnt_q <= '0;
            else if (!in_drain) cnt_q <= cnt_q + 1'b1;
         end
         if (xfer && last_q && (pkt_q != '1)) pkt_q <= pkt_q + 1'b1;
      end
   end

   always_comb begin
      buffer_TDATA    = data_q;
      buffer_TLAST    = last_q;
      buffer_TVALID   = vld_q;
      reorder_tag     = otag_q;
      tag_alloc_valid = alloc_q;
      tag_alloc       = alloc_tag_q;
      pkt_count       = pkt_q;
   end

endmodule
